qpp_read_addr_gen: RTL and testbench
====================================

// Module: qpp_read_addr_gen
// PURPOSE
//  Read-side controller for the 8-port interleaver bit RAM. After a block is
//  written, generates 8 quadratic-permutation (QPP) read addresses per cycle:
//  pi(i) = (f1*i + f2*i^2) mod K. It drives the RAM read_addr0..7 ports,
//  captures the 8 combinational data_out bits into an output register, and
//  hands them downstream with a valid/ready handshake. Sits directly
//  downstream of the RAM and feeds the rate-matching/output stage.
// PARAMETERS
//  ADDR_W  13  RAM address width; also the width of K, f1 and f2.
// PORTS
//  clk            in   1       sole clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  start          in   1       1-cycle pulse; latch K/f1/f2 and begin block
//  blk_len        in   ADDR_W  K; multiple of 8, 8 <= K <= 2^ADDR_W-8
//  f1             in   ADDR_W  QPP coefficient, f1 < K
//  f2             in   ADDR_W  QPP coefficient, f2 < K
//  read_addr0..7  out  ADDR_W  to RAM; lane j = pi(8m+j) for group m
//  ram_data       in   8       RAM data_out7..0; bit j pairs with read_addrj
//  bits           out  8       registered interleaved bits; bit j = lane j
//  bits_valid     out  1       bits holds a group
//  bits_ready     in   1       downstream accepts bits this cycle
//  busy           out  1       high in SETUP and RUN
//  done           out  1       1-cycle pulse after the last group is accepted
//  err            out  1       1-cycle pulse: start with illegal K
// BEHAVIOUR
//  Reset: state=IDLE; read_addr*=0, bits=0, bits_valid=0, busy=0, done=0,
//   err=0. Reset mid-block abandons the block; nothing resumes.
//  IDLE: start with legal K -> latch K,f1,f2, go to SETUP. Illegal K
//   (K%8!=0, K<8, K>2^ADDR_W-8) -> err for one cycle, stay IDLE.
//   start is ignored outside IDLE.
//  Mod-add: s = a+b in ADDR_W+1 bits; result = (s>=K) ? s-K : s. Both operands
//   are always < K. Modular subtract is a + (K-b) under the same rule.
//  SETUP (16 cycles, i=0..15): serial walk p<=p+g, g<=g+2f2 mod K, starting
//   at p=0, g=(f1+f2) mod K. i<8: lane j=i loads base[j]=p. i>=8: lane
//   j=i-8 loads d[j]=(p-base[j]) mod K. In parallel, c=f2 is doubled mod K
//   7 times, giving c=128*f2 mod K. Then RUN with m=0.
//  RUN: read_addrj = base[j]. advance = !bits_valid || bits_ready. On
//   advance: bits<=ram_data, bits_valid<=1, base[j]<=base[j]+d[j],
//   d[j]<=d[j]+c (mod K), m<=m+1. On bits_ready with no new load, clear
//   bits_valid. The group with m=K/8-1 is the last load; go to DRAIN.
//  DRAIN: hold until the final group is accepted (bits_valid && bits_ready),
//   then pulse done, clear bits_valid, go to IDLE. busy stays high in DRAIN.
//  Throughput: 1 group/cycle when bits_ready is held high. First bits_valid
//   is 17 cycles after start.
//  Backpressure: while bits_valid && !bits_ready, bits, read_addr* and all
//   lane state hold.
//  read_addr* keep their last value in IDLE. The RAM must not be rewritten
//   while busy.
// STRUCTURE
//  interleaver_pkg: ADDR_W, LANES=8, state enum {IDLE,SETUP,RUN,DRAIN},
//   SETUP_CYCLES=16.
//  Sub-module qpp_mod_add (a, b, k -> sum mod k) is combinational and used
//   for the walk, doubling and the 8 lanes.
//  Lane registers base[0:7] and d[0:7] are arrays; the controller is one FSM
//   plus a group counter m (ADDR_W-3 bits).
// TESTING
//  K=40,f1=3,f2=10, RAM bit a = a[0], ready=1 -> group0 addrs
//   0,13,6,19,12,25,18,31; 5 groups with no bubble; done 1 cycle after the
//   last accept.
//  K=6144,f1=263,f2=480 -> all 6144 addresses match a reference model, each
//   0..6143 appears exactly once, 768 groups.
//  Random bits_ready (50%) -> bits/addr stable while stalled; sequence
//   identical to the no-stall run; no group lost or duplicated.
//  start with K=44 or K=0 -> err pulses once, busy stays 0, no bits_valid.
//  rst_n low mid-RUN at group 3 -> all outputs return to reset values
//   immediately; a new start then gives the correct group0.
//  K=8 (single group) and start pulsed while busy -> exactly one group, one
//   done, and the extra start is ignored.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared constants and controller state encoding for the interleaver read side.
package interleaver_pkg;

    localparam int ADDR_W       = 13;
    localparam int LANES        = 8;
    localparam int SETUP_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/qpp_mod_add.sv
// Combinational modular add: o_sum = (i_a + i_b) mod i_k, both operands below i_k.
module qpp_mod_add #(
    parameter int W = 13
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_k,
    output logic [W-1:0] o_sum
);

    logic [W:0] w_sum;
    logic [W:0] w_red;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_red = w_sum - {1'b0, i_k};
    assign o_sum = (w_sum >= {1'b0, i_k}) ? w_red[W-1:0] : w_sum[W-1:0];

endmodule

// File: rtl/qpp_read_addr_gen.sv
// QPP read-address generator: 8 interleaved addresses per cycle, captures RAM bits
// and hands each 8-bit group downstream over a valid/ready handshake.
module qpp_read_addr_gen #(
    parameter int ADDR_W = interleaver_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] blk_len,
    input  logic [ADDR_W-1:0] f1,
    input  logic [ADDR_W-1:0] f2,
    output logic [ADDR_W-1:0] read_addr0,
    output logic [ADDR_W-1:0] read_addr1,
    output logic [ADDR_W-1:0] read_addr2,
    output logic [ADDR_W-1:0] read_addr3,
    output logic [ADDR_W-1:0] read_addr4,
    output logic [ADDR_W-1:0] read_addr5,
    output logic [ADDR_W-1:0] read_addr6,
    output logic [ADDR_W-1:0] read_addr7,
    input  logic [7:0]        ram_data,
    output logic [7:0]        bits,
    output logic              bits_valid,
    input  logic              bits_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import interleaver_pkg::*;

    localparam logic [ADDR_W-1:0] K_MAX      = {{(ADDR_W-3){1'b1}}, 3'b000};
    localparam logic [ADDR_W-4:0] M_ONE      = {{(ADDR_W-4){1'b0}}, 1'b1};
    localparam logic [3:0]        LAST_SETUP = 4'(SETUP_CYCLES - 1);

    state_e r_state;
    state_e w_state_nxt;

    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_f2x2;
    logic [ADDR_W-1:0] r_p;
    logic [ADDR_W-1:0] r_g;
    logic [ADDR_W-1:0] r_c;
    logic [3:0]        r_i;
    logic [ADDR_W-4:0] r_m;
    logic [ADDR_W-1:0] r_base [LANES];
    logic [ADDR_W-1:0] r_d    [LANES];
    logic [7:0]        r_bits;
    logic              r_bits_valid;
    logic              r_done;
    logic              r_err;

    logic [ADDR_W-1:0] w_base_nxt [LANES];
    logic [ADDR_W-1:0] w_d_nxt    [LANES];
    logic [ADDR_W-1:0] w_g_init;
    logic [ADDR_W-1:0] w_f2x2_init;
    logic [ADDR_W-1:0] w_p_nxt;
    logic [ADDR_W-1:0] w_g_nxt;
    logic [ADDR_W-1:0] w_c_dbl;
    logic [ADDR_W-1:0] w_neg_base;
    logic [ADDR_W-1:0] w_dsub;
    logic [ADDR_W-4:0] w_last_m;
    logic              w_k_legal;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_adv;
    logic              w_last;
    logic              w_final_acc;
    logic              w_busy;

    assign w_k_legal   = (blk_len[2:0] == 3'b000) && (blk_len != '0) && (blk_len <= K_MAX);
    assign w_start_ok  = start && (r_state == IDLE) && w_k_legal;
    assign w_start_bad = start && (r_state == IDLE) && !w_k_legal;
    assign w_adv       = (r_state == RUN) && (!r_bits_valid || bits_ready);
    assign w_last_m    = r_k[ADDR_W-1:3] - M_ONE;
    assign w_last      = (r_m == w_last_m);
    assign w_final_acc = (r_state == DRAIN) && r_bits_valid && bits_ready;

    // Initial walk values use the incoming K since r_k is loaded on the same edge.
    qpp_mod_add #(.W(ADDR_W)) u_g_init (.i_a(f1), .i_b(f2), .i_k(blk_len), .o_sum(w_g_init));
    qpp_mod_add #(.W(ADDR_W)) u_f2x2   (.i_a(f2), .i_b(f2), .i_k(blk_len), .o_sum(w_f2x2_init));
    qpp_mod_add #(.W(ADDR_W)) u_walk_p (.i_a(r_p), .i_b(r_g), .i_k(r_k), .o_sum(w_p_nxt));
    qpp_mod_add #(.W(ADDR_W)) u_walk_g (.i_a(r_g), .i_b(r_f2x2), .i_k(r_k), .o_sum(w_g_nxt));
    qpp_mod_add #(.W(ADDR_W)) u_c_dbl  (.i_a(r_c), .i_b(r_c), .i_k(r_k), .o_sum(w_c_dbl));

    // p - base is p + (K - base); base == 0 gives K - 0 = K, which still reduces to p.
    assign w_neg_base = r_k - r_base[r_i[2:0]];
    qpp_mod_add #(.W(ADDR_W)) u_dsub   (.i_a(r_p), .i_b(w_neg_base), .i_k(r_k), .o_sum(w_dsub));

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        qpp_mod_add #(.W(ADDR_W)) u_base (.i_a(r_base[j]), .i_b(r_d[j]), .i_k(r_k), .o_sum(w_base_nxt[j]));
        qpp_mod_add #(.W(ADDR_W)) u_d    (.i_a(r_d[j]), .i_b(r_c), .i_k(r_k), .o_sum(w_d_nxt[j]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_state_nxt = SETUP;
            end
            SETUP: begin
                w_busy = 1'b1;
                if (r_i == LAST_SETUP) w_state_nxt = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_adv && w_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (w_final_acc) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_f2x2 <= '0;
            r_p    <= '0;
            r_g    <= '0;
            r_c    <= '0;
            r_i    <= '0;
            r_m    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_k    <= blk_len;
                        r_f2x2 <= w_f2x2_init;
                        r_p    <= '0;
                        r_g    <= w_g_init;
                        r_c    <= f2;
                        r_i    <= '0;
                        r_m    <= '0;
                    end
                end
                SETUP: begin
                    r_p <= w_p_nxt;
                    r_g <= w_g_nxt;
                    // Seven doublings leave c = 128*f2 mod K, the second difference per group.
                    if (r_i < 4'd7) r_c <= w_c_dbl;
                    r_i <= r_i + 4'd1;
                end
                RUN: begin
                    if (w_adv) r_m <= r_m + M_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < LANES; j++) begin
                r_base[j] <= '0;
                r_d[j]    <= '0;
            end
        end else if (r_state == SETUP) begin
            if (!r_i[3]) r_base[r_i[2:0]] <= r_p;
            else         r_d[r_i[2:0]]    <= w_dsub;
        end else if (w_adv) begin
            for (int j = 0; j < LANES; j++) begin
                r_base[j] <= w_base_nxt[j];
                r_d[j]    <= w_d_nxt[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bits       <= '0;
            r_bits_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= w_final_acc;
            r_err  <= w_start_bad;
            if (w_adv) begin
                r_bits       <= ram_data;
                r_bits_valid <= 1'b1;
            end else if (bits_ready) begin
                r_bits_valid <= 1'b0;
            end
        end
    end

    assign read_addr0 = r_base[0];
    assign read_addr1 = r_base[1];
    assign read_addr2 = r_base[2];
    assign read_addr3 = r_base[3];
    assign read_addr4 = r_base[4];
    assign read_addr5 = r_base[5];
    assign read_addr6 = r_base[6];
    assign read_addr7 = r_base[7];
    assign bits       = r_bits;
    assign bits_valid = r_bits_valid;
    assign busy       = w_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_qpp_read_addr_gen.sv
// Bench for qpp_read_addr_gen: scoreboard of QPP groups, RAM model bit = addr[0].
`timescale 1ns/1ps
module tb_qpp_read_addr_gen;

    localparam int AW = 13;
    localparam int GW = 8 * AW;
    localparam int G0 [8] = '{0, 13, 6, 19, 12, 25, 18, 31};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          bits_ready = 1'b1;
    logic [AW-1:0] blk_len = '0;
    logic [AW-1:0] f1 = '0;
    logic [AW-1:0] f2 = '0;
    logic [AW-1:0] read_addr0, read_addr1, read_addr2, read_addr3;
    logic [AW-1:0] read_addr4, read_addr5, read_addr6, read_addr7;
    logic [7:0]    ram_data;
    logic [7:0]    bits;
    logic          bits_valid, busy, done, err;
    logic [AW-1:0] ra [8];

    int checks = 0;
    int failures = 0;

    logic          rand_ready = 1'b0;
    logic          model_busy = 1'b0;
    logic          pend_err = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b1;
    logic [7:0]    prev_bits = '0;
    logic [GW-1:0] prev_addr = '0;
    int            groups = 0;
    int            n_acc = 0;
    int            blk_loads = 0;
    int            n_done_obs = 0;
    int            seen [8192];
    logic [GW-1:0] sb [$];

    qpp_read_addr_gen #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .blk_len(blk_len), .f1(f1), .f2(f2),
        .read_addr0(read_addr0), .read_addr1(read_addr1),
        .read_addr2(read_addr2), .read_addr3(read_addr3),
        .read_addr4(read_addr4), .read_addr5(read_addr5),
        .read_addr6(read_addr6), .read_addr7(read_addr7),
        .ram_data(ram_data), .bits(bits), .bits_valid(bits_valid),
        .bits_ready(bits_ready), .busy(busy), .done(done), .err(err)
    );

    assign ra[0] = read_addr0;
    assign ra[1] = read_addr1;
    assign ra[2] = read_addr2;
    assign ra[3] = read_addr3;
    assign ra[4] = read_addr4;
    assign ra[5] = read_addr5;
    assign ra[6] = read_addr6;
    assign ra[7] = read_addr7;

    always_comb begin
        ram_data = '0;
        for (int j = 0; j < 8; j++) ram_data[j] = ra[j][0];
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] pi_f(input int i, input int k, input int a, input int b);
        longint v;
        v = (longint'(a) * i + longint'(b) * i * i) % k;
        return AW'(v);
    endfunction

    // Reference model and scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        logic [GW-1:0] cur;
        logic [GW-1:0] e;
        logic [7:0]    eb;
        logic          acc, exp_done, k_ok;
        for (int j = 0; j < 8; j++) cur[j*AW +: AW] = ra[j];
        if (!rst_n) begin
            sb.delete();
            model_busy = 1'b0;
            pend_err   = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b1;
        end else begin
            if ((!prev_valid || prev_ready) && bits_valid) begin
                chk("group_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    for (int j = 0; j < 8; j++) eb[j] = e[j*AW];
                    chk("group_addr", prev_addr, e);
                    chk("group_bits", bits, eb);
                    for (int j = 0; j < 8; j++) seen[prev_addr[j*AW +: AW]]++;
                    blk_loads++;
                end
            end
            if (prev_valid && !prev_ready) begin
                chk("stall_bits", bits, prev_bits);
                chk("stall_addr", cur, prev_addr);
                chk("stall_valid", bits_valid, 1'b1);
            end
            acc = prev_valid && prev_ready;
            if (acc) n_acc++;
            exp_done = acc && model_busy && (n_acc == groups);
            if (exp_done) model_busy = 1'b0;
            chk("done", done, exp_done);
            chk("busy", busy, model_busy);
            chk("err", err, pend_err);
            if (done) n_done_obs++;

            k_ok = (blk_len[2:0] == 3'b000) && (blk_len != '0) && (blk_len <= 13'd8184);
            pend_err = start && !model_busy && !k_ok;
            if (start && !model_busy && k_ok) begin
                model_busy = 1'b1;
                groups     = int'(blk_len) / 8;
                n_acc      = 0;
                blk_loads  = 0;
                foreach (seen[a]) seen[a] = 0;
                for (int g = 0; g < groups; g++) begin
                    for (int j = 0; j < 8; j++)
                        e[j*AW +: AW] = pi_f(8 * g + j, int'(blk_len), int'(f1), int'(f2));
                    sb.push_back(e);
                end
            end

            if (rand_ready) bits_ready = ($urandom_range(0, 1) == 1);
            else            bits_ready = 1'b1;
            prev_valid = bits_valid;
            prev_ready = bits_ready;
            prev_bits  = bits;
            prev_addr  = cur;
        end
    end

    task automatic pulse_start(input int k, input int a, input int b);
        @(posedge clk); #1;
        start   = 1'b1;
        blk_len = AW'(k);
        f1      = AW'(a);
        f2      = AW'(b);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (model_busy && n < max) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, model_busy, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        for (int j = 0; j < 8; j++) chk({tag, "_addr"}, ra[j], '0);
        chk({tag, "_bits"}, bits, '0);
        chk({tag, "_valid"}, bits_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    task automatic chk_perm(input int k, input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < k; a++) if (seen[a] != 1) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        int cyc;
        int d0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // Small block, ready held high: latency, group0 addresses, no bubbles, done timing.
        pulse_start(40, 3, 10);
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1;
            if (c == 16) begin
                for (int j = 0; j < 8; j++) chk("t1_group0_addr", ra[j], G0[j]);
                chk("t1_not_yet_valid", bits_valid, 1'b0);
            end
            if (c >= 17 && c <= 21) chk("t1_no_bubble", bits_valid, 1'b1);
            if (c == 21) chk("t1_done_early", done, 1'b0);
            if (c == 22) begin
                chk("t1_done", done, 1'b1);
                chk("t1_idle", busy, 1'b0);
            end
        end
        chk("t1_groups", blk_loads, 5);

        // Full-size block without stalls, then with random backpressure.
        pulse_start(6144, 263, 480);
        wait_idle(2000, "t2_timeout");
        chk("t2_groups", blk_loads, 768);
        chk_perm(6144, "t2_perm");

        rand_ready = 1'b1;
        pulse_start(6144, 263, 480);
        wait_idle(5000, "t3_timeout");
        rand_ready = 1'b0;
        chk("t3_groups", blk_loads, 768);
        chk_perm(6144, "t3_perm");

        // Illegal lengths.
        pulse_start(44, 1, 2);
        chk("t4_err44", err, 1'b1);
        chk("t4_busy44", busy, 1'b0);
        @(posedge clk); #1;
        chk("t4_err44_pulse", err, 1'b0);
        pulse_start(0, 0, 0);
        chk("t4_err0", err, 1'b1);
        chk("t4_busy0", busy, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t4_no_valid", bits_valid, 1'b0);
        chk("t4_err0_pulse", err, 1'b0);

        // Reset in the middle of a block, then a clean restart.
        pulse_start(40, 3, 10);
        cyc = 0;
        while (blk_loads < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        chk("t5_reached_group3", blk_loads, 3);
        #1 rst_n = 1'b0;
        #1 chk_reset("t5_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_start(40, 3, 10);
        wait_idle(200, "t5_timeout");
        chk("t5_groups", blk_loads, 5);

        // Single-group block with a start pulse while busy.
        d0 = n_done_obs;
        pulse_start(8, 5, 3);
        repeat (5) @(posedge clk);
        pulse_start(40, 3, 10);
        wait_idle(200, "t6_timeout");
        repeat (30) @(posedge clk);
        #1;
        chk("t6_groups", blk_loads, 1);
        chk("t6_done_count", n_done_obs - d0, 1);
        chk("t6_idle", busy, 1'b0);
        chk("t6_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
